// File: rtl/fetch_queue.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fetch_queue                                                               |
// | Fetch PC owner plus first-word-fall-through prefetch FIFO feeding decode. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              PCF,
  input  logic [31:0]              InstrF,
  input  logic                     RedirectValid,
  input  logic [31:0]              RedirectPC,
  input  logic                     DecReady,
  output logic                     DecValid,
  output logic [31:0]              InstrD,
  output logic [31:0]              PCD,
  output logic [31:0]              PCPlus8D,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  logic [31:0]   pcf_q, pcf_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic w_full;
  logic w_deq;
  logic w_enq;
  logic w_unused;

  // Low bits of the redirect target are forced to zero, never consumed.
  assign w_unused = ^RedirectPC[1:0];

  assign w_full   = (cnt_q == c_depth);
  assign DecValid = (cnt_q != '0);
  assign w_deq    = DecValid & DecReady;
  assign w_enq    = !RedirectValid & (!w_full | w_deq);

  always_comb begin
    pcf_d    = pcf_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (RedirectValid) begin
      // Flush discards even a head being accepted this cycle.
      pcf_d    = {RedirectPC[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (w_enq) begin
        pcf_d    = pcf_q + 32'd4;
        wr_ptr_d = wr_ptr_q + c_ptr_one;
      end
      if (w_deq) begin
        rd_ptr_d = rd_ptr_q + c_ptr_one;
      end
      cnt_d = cnt_q + {{AW{1'b0}}, w_enq} - {{AW{1'b0}}, w_deq};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q    <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pcf_q    <= pcf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_enq) begin
      instr_mem_q[wr_ptr_q] <= InstrF;
      pc_mem_q[wr_ptr_q]    <= pcf_q;
    end
  end

  assign PCF      = pcf_q;
  assign Count    = cnt_q;
  assign InstrD   = DecValid ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign PCD      = DecValid ? pc_mem_q[rd_ptr_q] : 32'd0;
  assign PCPlus8D = DecValid ? (pc_mem_q[rd_ptr_q] + 32'd8) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_fetch_queue                                                            |
// | Directed vector bench for fetch_queue (default and wrapping RESET_PC).    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'hE04F000F;
      30'd1:   return 32'hE2802005;
      default: return a ^ 32'h5A00_0000;
    endcase
  endfunction

  // DUT A: RESET_PC = 0
  logic        rst_a, rv_a, rdy_a;
  logic [31:0] rpc_a, pcf_a, instrf_a, instrd_a, pcd_a, pc8_a;
  logic        dv_a;
  logic [2:0]  cnt_a;
  assign instrf_a = imem(pcf_a);

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut_a (
    .clk(clk), .reset(rst_a), .PCF(pcf_a), .InstrF(instrf_a),
    .RedirectValid(rv_a), .RedirectPC(rpc_a), .DecReady(rdy_a),
    .DecValid(dv_a), .InstrD(instrd_a), .PCD(pcd_a), .PCPlus8D(pc8_a),
    .Count(cnt_a)
  );

  // DUT B: RESET_PC at the top of the address space
  logic        rst_b, rdy_b;
  logic [31:0] pcf_b, instrf_b, instrd_b, pcd_b, pc8_b;
  logic        dv_b;
  logic [2:0]  cnt_b;
  assign instrf_b = imem(pcf_b);

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .reset(rst_b), .PCF(pcf_b), .InstrF(instrf_b),
    .RedirectValid(1'b0), .RedirectPC(32'h0), .DecReady(rdy_b),
    .DecValid(dv_b), .InstrD(instrd_b), .PCD(pcd_b), .PCPlus8D(pc8_b),
    .Count(cnt_b)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        v;
    logic [31:0] pcd;
    logic [31:0] ins;
    logic [2:0]  cnt;
    logic [31:0] pcf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic v, input logic [31:0] pcd,
                     input logic [2:0] cnt, input logic [31:0] pcf);
    vec_t e;
    e.rst = rst; e.rv = rv; e.rpc = rpc; e.rdy = rdy;
    e.v = v; e.pcd = pcd; e.ins = v ? imem(pcd) : 32'h0; e.cnt = cnt; e.pcf = pcf;
    vecs.push_back(e);
  endtask

  task automatic check_a(input string tag, input logic v, input logic [31:0] pcd,
                         input logic [2:0] cnt, input logic [31:0] pcf);
    chk({tag, ".DecValid"}, {31'd0, dv_a}, {31'd0, v});
    chk({tag, ".PCD"},      pcd_a, v ? pcd : 32'h0);
    chk({tag, ".InstrD"},   instrd_a, v ? imem(pcd) : 32'h0);
    chk({tag, ".PCPlus8D"}, pc8_a, v ? pcd + 32'd8 : 32'h0);
    chk({tag, ".Count"},    {29'd0, cnt_a}, {29'd0, cnt});
    chk({tag, ".PCF"},      pcf_a, pcf);
  endtask

  initial begin
    rst_a = 1'b1; rv_a = 1'b0; rpc_a = 32'h0; rdy_a = 1'b0;
    rst_b = 1'b1; rdy_b = 1'b1;

    //   rst rv  rpc           rdy  v   pcd           cnt  pcf
    add(1, 0, 32'h0,        0,  0, 32'h0,        0, 32'h00);
    add(0, 0, 32'h0,        0,  1, 32'h0,        1, 32'h04);
    add(0, 0, 32'h0,        0,  1, 32'h0,        2, 32'h08);
    add(0, 0, 32'h0,        0,  1, 32'h0,        3, 32'h0C);
    add(0, 0, 32'h0,        0,  1, 32'h0,        4, 32'h10);
    add(0, 0, 32'h0,        0,  1, 32'h0,        4, 32'h10);
    add(0, 0, 32'h0,        0,  1, 32'h0,        4, 32'h10);
    add(0, 0, 32'h0,        1,  1, 32'h4,        4, 32'h14);
    add(0, 0, 32'h0,        1,  1, 32'h8,        4, 32'h18);
    add(1, 0, 32'h0,        0,  0, 32'h0,        0, 32'h00);
    add(0, 0, 32'h0,        0,  1, 32'h0,        1, 32'h04);
    add(0, 0, 32'h0,        0,  1, 32'h0,        2, 32'h08);
    add(0, 0, 32'h0,        1,  1, 32'h4,        2, 32'h0C);
    add(0, 0, 32'h0,        0,  1, 32'h4,        3, 32'h10);
    add(0, 1, 32'h4E,       1,  0, 32'h0,        0, 32'h4C);
    add(0, 0, 32'h0,        0,  1, 32'h4C,       1, 32'h50);
    add(0, 0, 32'h0,        1,  1, 32'h50,       1, 32'h54);
    add(0, 0, 32'h0,        1,  1, 32'h54,       1, 32'h58);
    add(0, 0, 32'h0,        0,  1, 32'h54,       2, 32'h5C);
    add(1, 1, 32'h80,       1,  0, 32'h0,        0, 32'h00);
    add(0, 0, 32'h0,        0,  1, 32'h0,        1, 32'h04);
    add(0, 1, 32'hFFFFFFFF, 0,  0, 32'h0,        0, 32'hFFFFFFFC);
    add(0, 0, 32'h0,        1,  1, 32'hFFFFFFFC, 1, 32'h00);
    add(0, 0, 32'h0,        1,  1, 32'h0,        1, 32'h04);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_a = vecs[i].rst; rv_a = vecs[i].rv; rpc_a = vecs[i].rpc; rdy_a = vecs[i].rdy;
      @(posedge clk);
      #1;
      check_a($sformatf("vec%0d", i), vecs[i].v, vecs[i].pcd, vecs[i].cnt, vecs[i].pcf);
    end

    // Sustained throughput: DecReady held high straight out of reset.
    @(negedge clk);
    rst_a = 1'b1; rv_a = 1'b0; rdy_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check_a($sformatf("stream%0d", i), 1'b1, 32'(i * 4), 3'd1, 32'(i * 4 + 4));
    end

    // Wrapping RESET_PC instance.
    @(negedge clk);
    chk("wrap.reset.PCF", pcf_b, 32'hFFFFFFFC);
    chk("wrap.reset.DecValid", {31'd0, dv_b}, 32'd0);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap.e1.PCF", pcf_b, 32'h0);
    chk("wrap.e1.PCD", pcd_b, 32'hFFFFFFFC);
    chk("wrap.e1.PCPlus8D", pc8_b, 32'h00000004);
    chk("wrap.e1.InstrD", instrd_b, imem(32'hFFFFFFFC));
    chk("wrap.e1.Count", {29'd0, cnt_b}, 32'd1);
    @(posedge clk);
    #1;
    chk("wrap.e2.PCD", pcd_b, 32'h0);
    chk("wrap.e2.InstrD", instrd_b, 32'hE04F000F);
    chk("wrap.e2.PCF", pcf_b, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that owns the fetch program counter (PCF).
- Drives PCF to the combinational word-aligned instruction memory and captures the returned word each cycle.
- Buffers fetched instructions and their addresses in a small prefetch FIFO.
- Presents them to decode with a valid/ready handshake; a redirect from execute flushes the FIFO and restarts fetch at the branch target.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- RESET_PC, 32'h00000000, value loaded into PCF on reset; word-aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- PCF  output  32  fetch address to instruction memory (memory indexes PCF[31:2]).
- InstrF  input  32  instruction word returned combinationally for the current PCF.
- RedirectValid  input  1  execute-stage branch/PC-write taken this cycle.
- RedirectPC  input  32  new fetch target; bits [1:0] ignored.
- DecReady  input  1  decode accepts the head entry this cycle.
- DecValid  output  1  head entry valid.
- InstrD  output  32  head instruction; 0 when DecValid=0.
- PCD  output  32  address of head instruction; 0 when DecValid=0.
- PCPlus8D  output  32  PCD+8 (architectural PC read value); 0 when DecValid=0.
- Count  output  $clog2(DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (any cycle, including mid-operation):
  - PCF<=RESET_PC; read/write pointers and Count<=0.
  - DecValid=0; InstrD/PCD/PCPlus8D=0.
  - No enqueue or dequeue occurs in the reset cycle.
- Definitions:
  - full = (Count==DEPTH).
  - deq = DecValid & DecReady.
  - enq = !RedirectValid & (!full | deq).
- Enqueue:
  - On enq, the entry {InstrF, PCF} is written at the write pointer and PCF<=PCF+4, mod 2^32 (32'hFFFFFFFC wraps to 0).
  - If !enq and !RedirectValid, PCF holds.
- Dequeue: on deq, the read pointer advances.
- FIFO:
  - First-word-fall-through: outputs are driven combinationally from the registered head entry.
  - An entry enqueued at edge N is visible at DecValid after edge N.
  - No same-cycle bypass from InstrF to InstrD.
- Pointers wrap modulo DEPTH.
- Count:
  - Count<=Count+enq-deq.
  - When full with deq=1, enq is permitted and Count stays DEPTH.
  - When empty, deq is impossible (DecValid=0).
- Redirect (highest priority below reset):
  - PCF<={RedirectPC[31:2],2'b00}.
  - Pointers and Count<=0, discarding all entries including any head being dequeued that cycle.
  - No enqueue that cycle.
  - DecValid=0 in the following cycle.
  - The first post-redirect entry is enqueued one cycle later and appears the cycle after that.
- PCPlus8D = PCD + 32'd8, mod 2^32.
- Latency:
  - Empty-queue fetch to DecValid: 1 cycle.
  - Redirect to first valid target instruction at decode: 2 cycles.
- Throughput: one instruction per cycle sustained while DecReady=1.
- Invariants:
  - DecValid == (Count!=0).
  - Count never exceeds DEPTH.
  - PCF[1:0]==0 at all times.

Test Plan:
- Reset, then DecReady=0 for 6 cycles, with memory word0=32'hE04F000F, word1=32'hE2802005 -> the sequence is:
  - DecValid rises after edge 1 with PCD=0, InstrD=32'hE04F000F, PCPlus8D=8.
  - Count reaches 4 after edge 4.
  - PCF holds 32'h10 thereafter with no further enqueue.
- From full, DecReady=1 for 1 cycle -> entry PCD=0 consumed; entry PCF=32'h10 enqueued; Count stays 4; next head PCD=4, InstrD=32'hE2802005; PCF=32'h14.
- DecReady=1 continuously from reset -> DecValid stays 1 from cycle 1; PCD increments by 4 every cycle (0,4,8,C...).
- With Count=3, assert RedirectValid, RedirectPC=32'h0000004E for 1 cycle, plus DecReady=1 -> next cycle Count=0, DecValid=0, PCF=32'h4C. One cycle later DecValid=1, PCD=32'h4C, PCPlus8D=32'h54.
- RESET_PC=32'hFFFFFFFC, DecReady=1 -> after first enqueue PCF=0; head PCD=32'hFFFFFFFC with PCPlus8D=32'h00000004.
- Assert reset mid-stream with Count=2 and RedirectValid=1 simultaneously -> reset wins: PCF=RESET_PC, Count=0, DecValid=0 next cycle; fetch resumes at RESET_PC.
